// File: rtl/mac_accumulator.sv
// mac_accumulator: sums N consecutive 8-bit unsigned products into one
// saturating ACC_W-bit result, with valid/ready on both sides. A two-state
// FSM alternates between accumulating (ACCUM) and presenting a finished
// result (HOLD). The sticky overflow flag reports any saturating addition
// within the result.
module mac_accumulator #(
   parameter int N     = 4,   // products per result, 1..255
   parameter int ACC_W = 12   // accumulator/result width, >= 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       prod,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf
);

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   logic [0:0]       r_state;
   logic [ACC_W-1:0] r_acc;
   logic [7:0]       r_cnt;
   logic             r_ovf;
   logic [ACC_W-1:0] r_out_sum;
   logic             r_out_ovf;

   logic             w_accept;
   logic             w_last;
   logic [ACC_W:0]   w_sum_ext;
   logic             w_add_ovf;
   logic [ACC_W-1:0] w_sum;

   // Handshake: clear blocks acceptance; input and output sides never overlap.
   assign in_ready  = (r_state == ST_ACCUM) & ~clear;
   assign out_valid = (r_state == ST_HOLD);
   assign w_accept  = in_valid & in_ready;
   assign w_last    = (r_cnt == 8'(N - 1));

   // Saturating add: carry out of the ACC_W-bit sum clamps to all-ones.
   assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W + 1 - 8){1'b0}}, prod};
   assign w_add_ovf = w_sum_ext[ACC_W];
   assign w_sum     = w_add_ovf ? '1 : w_sum_ext[ACC_W-1:0];

   assign out_sum = r_out_sum;
   assign out_ovf = r_out_ovf;

   // FSM, partial sum, term count and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_ACCUM;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (clear) begin
                  r_acc <= '0;
                  r_cnt <= '0;
                  r_ovf <= 1'b0;
               end else if (w_accept) begin
                  if (w_last) begin
                     r_acc   <= '0;
                     r_cnt   <= '0;
                     r_ovf   <= 1'b0;
                     r_state <= ST_HOLD;
                  end else begin
                     r_acc <= w_sum;
                     r_cnt <= r_cnt + 8'd1;
                     r_ovf <= r_ovf | w_add_ovf;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  r_state <= ST_ACCUM;
               end
            end
            default: r_state <= ST_ACCUM;
         endcase
      end
   end

   // Result registers load only on the final accept of a result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_sum <= '0;
         r_out_ovf <= 1'b0;
      end else if ((r_state == ST_ACCUM) && w_accept && w_last) begin
         r_out_sum <= w_sum;
         r_out_ovf <= r_ovf | w_add_ovf;
      end
   end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential accumulation stage that sits directly downstream of the 4x4 combinational multiplier. It consumes the 8-bit unsigned product stream through a valid/ready handshake and sums N consecutive products into one result, producing a dot product. It presents each result on a valid/ready output port with a saturation flag.

## Interface
- N, 4: products summed per result; legal range 1..255.
- ACC_W, 12: accumulator and result width; must be >= 8.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of the partial sum and count; ignored in HOLD.
- in_valid  in  1  prod is valid this cycle.
- in_ready  out  1  block accepts prod this cycle; combinational: (state==ACCUM) & ~clear.
- prod  in  8  unsigned product from the multiplier.
- out_valid  out  1  out_sum and out_ovf are valid.
- out_ready  in  1  downstream takes the result.
- out_sum  out  ACC_W  completed sum, saturated to 2^ACC_W-1.
- out_ovf  out  1  set if any addition in this result saturated.

## Operation
- The state machine has two states: ACCUM and HOLD.
- Internal registers:
  - acc[ACC_W-1:0]
  - cnt[7:0]
  - ovf (sticky)
  - out_sum and out_ovf (output registers)
- Accept event: in_valid & in_ready.
- Add rule: compute acc + zero-extended prod at width ACC_W+1.
  - If bit ACC_W is set, the result is all-ones and ovf is set.
  - Otherwise the result is the low ACC_W bits.
- ACCUM, on accept with cnt != N-1:
  - acc <= sum
  - cnt <= cnt+1
  - stay in ACCUM
- ACCUM, on accept with cnt == N-1:
  - out_sum <= sum, out_ovf <= ovf | this overflow
  - acc <= 0, cnt <= 0, ovf <= 0
  - go to HOLD
- ACCUM with clear high: acc, cnt and ovf go to 0; no input is accepted (clear wins over in_valid).
- HOLD:
  - in_ready=0 and out_valid=1.
  - out_sum and out_ovf are held stable.
  - On out_ready, go to ACCUM.
- N=1: every accepted product is a complete result.
- out_sum and out_ovf change only on the transition into HOLD.

## Timing
- Reset (async, rst_n=0): state=ACCUM, acc=0, cnt=0, ovf=0, out_sum=0, out_ovf=0, out_valid=0.
  - in_ready follows ~clear immediately after reset.
- Latency: out_valid rises the cycle after the Nth accept.
- Throughput: one product per cycle in ACCUM.
  - One bubble per result: the cycle out_ready is sampled in HOLD accepts no input.
  - Peak rate is N products per N+1 cycles.
- in_ready and out_valid are never both high.
- Backpressure: HOLD persists indefinitely while out_ready=0; prod is not accepted.
- in_valid with in_ready=0 is not accepted; upstream must hold prod until accepted.
- out_ready while in ACCUM has no effect.
- rst_n low mid-sum or in HOLD: the partial sum and any pending result are discarded; all registers return to reset values asynchronously.
- clear in HOLD is ignored; clear in the same cycle as the Nth in_valid cancels that accept and the result.

## Test plan
- Reset, N=4, ACC_W=12:
  - Stimulus: products 3, 5, 7, 9 on consecutive cycles with out_ready=1.
  - Response: out_valid pulses one cycle after the 4th accept; out_sum=24, out_ovf=0; in_ready low for exactly 1 cycle.
- Maximum values, N=4:
  - Stimulus: four products of 225.
  - Response: out_sum=900, out_ovf=0.
- Saturation, N=8, ACC_W=10:
  - Stimulus: eight products of 225.
  - Response: out_sum=1023, out_ovf=1.
  - Next result from eight products of 1: out_sum=8, out_ovf=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after the result, with in_valid=1 throughout.
  - Response: in_ready=0 and out_sum stable for all 5 cycles; the first product accepted after out_ready is the first term of the next sum.
- Clear, N=4:
  - Stimulus: accept 10 and 20, then assert clear together with in_valid and prod=30, then accept 1, 2, 3, 4.
  - Response: 30 is not accepted; out_sum=10.
- Reset mid-operation:
  - Stimulus: drive rst_n low between clock edges after 2 accepts, or while in HOLD.
  - Response: out_valid=0 and out_sum=0 immediately; the next 4 accepts of 1 give out_sum=4.
  - N=1: products 200 and 50 produce two results, 200 then 50.
